xge_loopback_ctrl: RTL and testbench

Run sequencer for the 10G MAC loopback self-test. It resets, arms and times the Tx packet generator and the Rx checker for a programmed number of iterations, then records each iteration's pass, fail or timeout outcome. It sits between the software/status register block and the tx_checker/rx_checker pair, all on the 156.25 MHz MAC clock.

---
 rtl/xge_loopback_ctrl.sv | 174 +++++++++++++++++
 tb/tb_xge_loopback_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xge_loopback_ctrl.sv
// Run sequencer for the 10G MAC loopback self-test: resets, arms and times the
// Tx generator / Rx checker per iteration and accumulates pass/fail/timeout results.
module xge_loopback_ctrl #(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk156,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_iter,
    input  logic [31:0]      timeout_cycles,
    input  logic             stop_on_fail,
    input  logic             rx_done,
    input  logic             rx_correct,
    input  logic [1:0]       rx_error,
    output logic             chk_rst,
    output logic             rx_enable,
    output logic             tx_enable,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_count,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic [2:0]       last_error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CRST   = 3'd1;
    localparam logic [2:0] S_ARM    = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_RECORD = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]       state_q, state_d;
    logic [RC_W-1:0]  rcnt_q, rcnt_d;
    logic [31:0]      wd_q, wd_d;
    logic [2:0]       code_q, code_d;
    logic [CNT_W-1:0] iter_q, iter_d, pass_q, pass_d, fail_q, fail_d;
    logic [2:0]       last_err_q, last_err_d;
    logic             chk_rst_q, chk_rst_d, rx_en_q, rx_en_d, tx_en_q, tx_en_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             aborting;

    // Next state, counters and registered-output values, all decoded from the next state
    always_comb begin
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        wd_d       = wd_q;
        code_d     = code_q;
        iter_d     = iter_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        last_err_d = last_err_q;
        aborting   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CRST;
                    iter_d     = '0;
                    pass_d     = '0;
                    fail_d     = '0;
                    last_err_d = 3'd0;
                end
            end
            S_CRST: begin
                if (rcnt_q == RC_W'(RST_CYCLES - 1)) begin
                    state_d = S_ARM;
                end else begin
                    rcnt_d = rcnt_q + RC_W'(1);
                end
            end
            S_ARM: begin
                state_d = S_RUN;
                wd_d    = 32'd0;
            end
            S_RUN: begin
                wd_d = wd_q + 32'd1;
                if (rx_done) begin
                    state_d = S_RECORD;
                    if (rx_correct)          code_d = 3'd0;
                    else if (rx_error == 2'd0) code_d = 3'd7;
                    else                     code_d = {1'b0, rx_error};
                end else if ((timeout_cycles != 32'd0) && (wd_q == timeout_cycles)) begin
                    state_d = S_RECORD;
                    code_d  = 3'd4;
                end
            end
            S_RECORD: begin
                iter_d = (iter_q == CNT_MAX) ? iter_q : iter_q + CNT_W'(1);
                if (code_q == 3'd0) begin
                    pass_d = (pass_q == CNT_MAX) ? pass_q : pass_q + CNT_W'(1);
                end else begin
                    fail_d     = (fail_q == CNT_MAX) ? fail_q : fail_q + CNT_W'(1);
                    last_err_d = code_q;
                end
                if (((num_iter != '0) && (iter_d == num_iter)) ||
                    ((code_q != 3'd0) && stop_on_fail)) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_CRST;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Abort discards the in-flight iteration and resets the checkers during FINISH
        if (abort && (state_q != S_IDLE) && (state_q != S_FINISH)) begin
            state_d    = S_FINISH;
            aborting   = 1'b1;
            iter_d     = iter_q;
            pass_d     = pass_q;
            fail_d     = fail_q;
            last_err_d = last_err_q;
        end

        if (state_d != S_CRST) rcnt_d = '0;

        // Enables stay up through RECORD so they fall two cycles after rx_done
        chk_rst_d = (state_d == S_CRST) || aborting;
        rx_en_d   = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_RECORD);
        tx_en_d   = (state_d == S_RUN) || (state_d == S_RECORD);
        busy_d    = (state_d != S_IDLE) && (state_d != S_FINISH);
        done_d    = (state_d == S_FINISH);
    end

    always_ff @(posedge clk156) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rcnt_q     <= '0;
            wd_q       <= 32'd0;
            code_q     <= 3'd0;
            iter_q     <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            last_err_q <= 3'd0;
            chk_rst_q  <= 1'b1;
            rx_en_q    <= 1'b0;
            tx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            wd_q       <= wd_d;
            code_q     <= code_d;
            iter_q     <= iter_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            last_err_q <= last_err_d;
            chk_rst_q  <= chk_rst_d;
            rx_en_q    <= rx_en_d;
            tx_en_q    <= tx_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign chk_rst    = chk_rst_q;
    assign rx_enable  = rx_en_q;
    assign tx_enable  = tx_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign iter_count = iter_q;
    assign pass_count = pass_q;
    assign fail_count = fail_q;
    assign last_error = last_err_q;

endmodule

// File: tb/tb_xge_loopback_ctrl.sv
// Bench for xge_loopback_ctrl: two instances (16-bit and 4-bit counters) share one
// stimulus stream; an Rx responder and an outcome model predict timing and counts.
module tb_xge_loopback_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort, stop_on_fail, rx_done, rx_correct;
    logic [1:0]  rx_error;
    logic [15:0] num_iter;
    logic [31:0] timeout_cycles;

    logic        a_chk, a_rxe, a_txe, a_busy, a_done;
    logic [15:0] a_iter, a_pass, a_fail;
    logic [2:0]  a_last;
    logic        b_chk, b_rxe, b_txe, b_busy, b_done;
    logic [3:0]  b_iter, b_pass, b_fail;
    logic [2:0]  b_last;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int         p_delay [64];
    bit         p_ok    [64];
    logic [1:0] p_err   [64];

    always #5 clk = ~clk;

    xge_loopback_ctrl #(.RST_CYCLES(4), .CNT_W(16)) dut16 (
        .clk156(clk), .rst(rst), .start(start), .abort(abort), .num_iter(num_iter),
        .timeout_cycles(timeout_cycles), .stop_on_fail(stop_on_fail), .rx_done(rx_done),
        .rx_correct(rx_correct), .rx_error(rx_error), .chk_rst(a_chk), .rx_enable(a_rxe),
        .tx_enable(a_txe), .busy(a_busy), .done(a_done), .iter_count(a_iter),
        .pass_count(a_pass), .fail_count(a_fail), .last_error(a_last));

    xge_loopback_ctrl #(.RST_CYCLES(4), .CNT_W(4)) dut4 (
        .clk156(clk), .rst(rst), .start(start), .abort(abort), .num_iter(num_iter[3:0]),
        .timeout_cycles(timeout_cycles), .stop_on_fail(stop_on_fail), .rx_done(rx_done),
        .rx_correct(rx_correct), .rx_error(rx_error), .chk_rst(b_chk), .rx_enable(b_rxe),
        .tx_enable(b_txe), .busy(b_busy), .done(b_done), .iter_count(b_iter),
        .pass_count(b_pass), .fail_count(b_fail), .last_error(b_last));

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return 32'((v > m) ? m : v);
    endfunction

    task automatic chk_cnt(input string tag, input int it, input int ps, input int fl, input int le);
        chk({tag, ".iter16"}, 32'(a_iter), sat(it, 16));
        chk({tag, ".pass16"}, 32'(a_pass), sat(ps, 16));
        chk({tag, ".fail16"}, 32'(a_fail), sat(fl, 16));
        chk({tag, ".last16"}, 32'(a_last), 32'(le));
        chk({tag, ".iter4"},  32'(b_iter), sat(it, 4));
        chk({tag, ".pass4"},  32'(b_pass), sat(ps, 4));
        chk({tag, ".fail4"},  32'(b_fail), sat(fl, 4));
        chk({tag, ".last4"},  32'(b_last), 32'(le));
    endtask

    task automatic plan(input int i, input int d, input bit ok, input logic [1:0] e);
        p_delay[i] = d;
        p_ok[i]    = ok;
        p_err[i]   = e;
    endtask

    // One run: Rx responder follows p_* per iteration; int_iter/int_off inject abort or rst.
    task automatic run(input int niter, input int tmo, input bit sof, input int nplan,
                       input int int_iter, input int int_off, input bit int_rst,
                       input bit busy_start);
        int it, ps, fl, le, o, e, r_off, code, last_k, k;
        bit fin, rx_prev;
        it = 0; ps = 0; fl = 0; le = 0;
        num_iter       = 16'(niter);
        timeout_cycles = 32'(tmo);
        stop_on_fail   = sof;
        o = cyc;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start.busy", 32'(a_busy), 1);
        chk("start.chk_rst", 32'(a_chk), 1);
        chk_cnt("start", 0, 0, 0, 0);
        for (int i = 0; i < nplan; i++) begin
            k = 0;
            rx_prev = 1'b0;
            while (!a_txe && k < 16) begin
                rx_prev = a_rxe;
                tick;
                k++;
            end
            if (!a_txe) begin
                chk("tx_rise.bound", 32'(a_txe), 1);
                return;
            end
            e = cyc;
            chk("tx_rise.lat", 32'(e - o), 6);
            chk("rx_lead", 32'(rx_prev), 1);
            chk("tx4", 32'(b_txe), 1);
            if (p_delay[i] >= 0 && (tmo == 0 || p_delay[i] <= tmo)) begin
                r_off = p_delay[i];
                code  = p_ok[i] ? 0 : ((p_err[i] == 2'd0) ? 7 : int'(p_err[i]));
            end else begin
                r_off = tmo;
                code  = 4;
            end
            last_k = (i == int_iter) ? int_off - 1 : r_off;
            for (k = 0; k <= last_k; k++) begin
                rx_done    = (k == p_delay[i]);
                rx_correct = (k == p_delay[i]) && p_ok[i];
                rx_error   = (k == p_delay[i]) ? p_err[i] : 2'd0;
                if (busy_start && i == 0 && k == 1) start = 1'b1;
                tick;
                start = 1'b0; rx_done = 1'b0; rx_correct = 1'b0; rx_error = 2'd0;
            end
            if (i == int_iter) begin
                if (int_rst) rst = 1'b1;
                else         abort = 1'b1;
                tick;
                abort = 1'b0;
                if (int_rst) begin
                    chk("rst.chk_rst", 32'(a_chk), 1);
                    chk("rst.busy", 32'(a_busy | b_busy), 0);
                    chk("rst.done", 32'(a_done | b_done), 0);
                    chk("rst.en", 32'({a_rxe, a_txe, b_rxe, b_txe}), 0);
                    chk_cnt("rst", 0, 0, 0, 0);
                    rst = 1'b0;
                    tick;
                    chk("rst.chk_rel", 32'(a_chk | b_chk), 0);
                    for (int j = 0; j < 8; j++) begin
                        chk("rst.nodone", 32'({a_done, b_done, a_busy, a_txe}), 0);
                        tick;
                    end
                end else begin
                    chk("abort.done", 32'({a_done, b_done}), 3);
                    chk("abort.chk_rst", 32'({a_chk, b_chk}), 3);
                    chk("abort.en", 32'({a_rxe, a_txe, b_rxe, b_txe}), 0);
                    chk("abort.busy", 32'(a_busy), 0);
                    chk_cnt("abort", it, ps, fl, le);
                    tick;
                    chk("abort.done_end", 32'(a_done), 0);
                    chk("abort.chk_end", 32'(a_chk), 0);
                end
                return;
            end
            chk("rec.tx", 32'(a_txe), 1);
            tick;
            it++;
            if (code == 0) ps++;
            else begin fl++; le = code; end
            fin = (niter != 0 && it == niter) || (code != 0 && sof);
            chk("drop_at", 32'(cyc - e), 32'(r_off + 2));
            chk("drop.en", 32'({a_rxe, a_txe, b_rxe, b_txe}), 0);
            chk_cnt("rec", it, ps, fl, le);
            if (fin) begin
                chk("fin.done", 32'({a_done, b_done}), 3);
                chk("fin.busy", 32'(a_busy), 0);
                tick;
                chk("fin.done_end", 32'(a_done), 0);
                chk("fin.busy_end", 32'(a_busy), 0);
                chk_cnt("hold", it, ps, fl, le);
                return;
            end
            chk("next.chk_rst", 32'(a_chk), 1);
            chk("next.done", 32'(a_done), 0);
            o = cyc - 1;
        end
        chk("plan.exhausted", 32'(0), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n, tmo;
        rst = 1'b1; start = 1'b0; abort = 1'b0; stop_on_fail = 1'b0;
        rx_done = 1'b0; rx_correct = 1'b0; rx_error = 2'd0;
        num_iter = 16'd0; timeout_cycles = 32'd0;
        tick; tick; tick;
        chk("reset.chk_rst", 32'({a_chk, b_chk}), 3);
        chk("reset.outs", 32'({a_rxe, a_txe, a_busy, a_done, b_busy, b_done}), 0);
        chk_cnt("reset", 0, 0, 0, 0);
        rst = 1'b0;
        tick;
        chk("reset.chk_rel", 32'(a_chk), 0);

        // three clean passes
        for (int i = 0; i < 3; i++) plan(i, 50, 1'b1, 2'd0);
        run(3, 0, 1'b0, 3, -1, 0, 1'b0, 1'b0);

        // stop on the data error in iteration 2
        for (int i = 0; i < 5; i++) plan(i, 20, 1'b1, 2'd0);
        plan(1, 20, 1'b0, 2'd2);
        run(5, 0, 1'b1, 5, -1, 0, 1'b0, 1'b0);

        // error code mapping without stop_on_fail
        plan(0, 10, 1'b1, 2'd0);
        plan(1, 12, 1'b0, 2'd0);
        plan(2, 9, 1'b0, 2'd3);
        plan(3, 11, 1'b0, 2'd1);
        run(4, 0, 1'b0, 4, -1, 0, 1'b0, 1'b0);

        // watchdog expiry, then rx_done on the match cycle
        plan(0, -1, 1'b1, 2'd0);
        run(1, 100, 1'b0, 1, -1, 0, 1'b0, 1'b0);
        plan(0, 100, 1'b1, 2'd0);
        run(1, 100, 1'b0, 1, -1, 0, 1'b0, 1'b0);

        // endless run aborted in iteration 4, with a start pulse while busy
        for (int i = 0; i < 4; i++) plan(i, 50, 1'b1, 2'd0);
        run(0, 0, 1'b0, 4, 3, 10, 1'b0, 1'b1);

        // 4-bit counters saturate over 20 passes, then abort
        for (int i = 0; i < 21; i++) plan(i, 3, 1'b1, 2'd0);
        run(0, 0, 1'b0, 21, 20, 2, 1'b0, 1'b0);

        // reset mid-run
        for (int i = 0; i < 3; i++) plan(i, 8, 1'b1, 2'd0);
        run(0, 0, 1'b0, 3, 2, 4, 1'b1, 1'b0);

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            n   = int'($urandom_range(1, 6));
            tmo = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(15, 50));
            for (int i = 0; i < n; i++) begin
                if (tmo != 0 && $urandom_range(0, 4) == 0) plan(i, -1, 1'b1, 2'd0);
                else plan(i, int'($urandom_range(1, 60)), ($urandom_range(0, 9) < 7),
                          2'($urandom_range(0, 3)));
            end
            run(n, tmo, 1'($urandom_range(0, 1)), n, -1, 0, 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
